// File: rtl/decode_ctrl.sv
// Fetch-to-decode handoff: a two-entry in-order skid buffer with load-use hazard
// stalling and a saturating bubble counter.
module decode_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [XLEN-1:0] f_instr,
  input  logic [XLEN-1:0] f_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_instr,
  output logic [XLEN-1:0] d_pc,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic [15:0]     stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  state_e          state_q;
  logic [XLEN-1:0] head_instr_q, head_pc_q;
  logic [XLEN-1:0] skid_instr_q, skid_pc_q;
  logic [15:0]     stall_cnt_q;

  logic       push, pop, hazard, not_empty;
  logic       uses_rs1, uses_rs2;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;

  assign opcode    = head_instr_q[6:0];
  assign rs1       = head_instr_q[19:15];
  assign rs2       = head_instr_q[24:20];
  assign not_empty = (state_q != EMPTY);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b1;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: uses_rs2 = 1'b0;
      default: ;
    endcase
  end

  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

  // f_ready comes from registered state only, so d_ready never reaches fetch.
  assign f_ready   = (state_q != FULL);
  assign d_valid   = not_empty && !hazard && !flush;
  assign d_instr   = not_empty ? head_instr_q : '0;
  assign d_pc      = not_empty ? head_pc_q : '0;
  assign stall_cnt = stall_cnt_q;

  assign push = f_valid && f_ready;
  assign pop  = d_valid && d_ready;

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (not_empty && hazard && !flush && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;

      if (flush) begin
        state_q <= EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: if (push) begin
            state_q      <= ONE;
            head_instr_q <= f_instr;
            head_pc_q    <= f_pc;
          end
          ONE: begin
            if (push && pop) begin
              head_instr_q <= f_instr;
              head_pc_q    <= f_pc;
            end else if (push) begin
              state_q      <= FULL;
              skid_instr_q <= f_instr;
              skid_pc_q    <= f_pc;
            end else if (pop) begin
              state_q <= EMPTY;
            end
          end
          FULL: if (pop) begin
            state_q      <= ONE;
            head_instr_q <= skid_instr_q;
            head_pc_q    <= skid_pc_q;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning width of the PC and instruction words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port f_valid, input, 1 bit: fetch offers an instruction.
REQ-005 SHALL have port f_ready, output, 1 bit: this block accepts the fetch offer.
REQ-006 SHALL have ports f_instr and f_pc, inputs, XLEN bits each: the fetched instruction and its PC.
REQ-007 SHALL have port d_valid, output, 1 bit: an instruction is presented to the decode breakdown.
REQ-008 SHALL have port d_ready, input, 1 bit: downstream accepts the presented instruction.
REQ-009 SHALL have ports d_instr and d_pc, outputs, XLEN bits each: the presented instruction and its PC.
REQ-010 SHALL have ports ex_valid (1), ex_is_load (1) and ex_rd (5), inputs: the instruction currently in execute.
REQ-011 SHALL have port flush, input, 1 bit: redirect; discard all buffered instructions.
REQ-012 SHALL have port stall_cnt, output, 16 bits: count of load-use bubble cycles, saturating.

Function
REQ-013 SHALL hold a 2-entry in-order buffer (head, skid) with states EMPTY, ONE and FULL.
REQ-014 SHALL drive f_ready = 1 exactly when the state is not FULL, from registered state only (no combinational path from d_ready).
REQ-015 SHALL treat a fetch transfer as f_valid & f_ready, and a decode transfer as d_valid & d_ready, both in the same cycle.
REQ-016 SHALL present the head entry on d_instr/d_pc whenever the state is not EMPTY; d_instr/d_pc SHALL be 0 when EMPTY.
REQ-017 SHALL decode head operand use from opcode = instr[6:0]: LUI 0110111, AUIPC 0010111 and JAL 1101111 use no source; OP-IMM 0010011, LOAD 0000011 and JALR 1100111 use rs1 = instr[19:15] only; all other opcodes use rs1 and rs2 = instr[24:20].
REQ-018 SHALL flag a hazard when ex_valid & ex_is_load & ex_rd != 0 and ex_rd equals a used source of the head.
REQ-019 SHALL drive d_valid = (state != EMPTY) & ~hazard & ~flush.
REQ-020 SHALL increment stall_cnt by 1 in each cycle where state != EMPTY & hazard & ~flush, holding at 16'hFFFF.
REQ-021 SHALL apply transitions as follows (push = fetch transfer, pop = decode transfer):
- EMPTY+push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE, with the new word becoming head.
- FULL: pop -> ONE, with skid moving to head; no push is possible.
REQ-022 SHALL give one cycle of latency from fetch transfer to d_valid: a word accepted at edge N is presented after edge N.
REQ-023 SHALL on flush = 1 force the state to EMPTY at the next edge, ignoring any same-cycle push or pop; the stall counter SHALL be kept.
REQ-024 SHALL preserve program order; no entry is duplicated or dropped except by flush.

Reset
REQ-025 SHALL on rst_n = 0 immediately set the state to EMPTY, f_ready = 1, d_valid = 0, d_instr = 0, d_pc = 0 and stall_cnt = 0, regardless of clk.
REQ-026 SHALL discard all buffered entries on reset asserted mid-operation, and SHALL resume from EMPTY on the first edge after rst_n rises.

Verification
REQ-027 SHALL cover: single push of instr 0x00500093 at pc 0x100 with d_ready = 1 -> d_valid = 1 next cycle with matching d_instr/d_pc, and state EMPTY after the pop.
REQ-028 SHALL cover: d_ready = 0 with two pushes (pc 0x100, 0x104) -> f_ready = 0 after the second; then d_ready = 1 -> 0x100 is popped, then 0x104, in order.
REQ-029 SHALL cover: head 0x002081B3 (add x3,x1,x2) with ex_valid = 1, ex_is_load = 1, ex_rd = 2 for 2 cycles -> d_valid = 0 for 2 cycles, stall_cnt = 2, then d_valid = 1.
REQ-030 SHALL cover: the same hazard with ex_rd = 0, and with head LUI 0x123452B7 and ex_rd = 5 -> no stall.
REQ-031 SHALL cover: FULL state with flush = 1 and f_valid = 1 -> EMPTY next cycle and d_valid = 0.
REQ-032 SHALL cover: rst_n pulsed low mid-stream between clock edges -> outputs reset immediately; stall_cnt forced to 0xFFFF by stimulus stays 0xFFFF under further hazards.
